// File: rtl/hash_uart_tx.sv
// hash_uart_tx: sends the digest over a UART line as 8N1 frames, most
// significant byte first. Only ceil(d/8) bytes go out, with d capped at
// MAX_BITS, and digest bits at or above that length are sent as zero.
// MAX_BITS is expected to be a power-of-two multiple of 8.
module hash_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_BITS     = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                transmit,
    input  logic [15:0]         d,
    input  logic [MAX_BITS-1:0] data,
    output logic                TxD,
    output logic                busy,
    output logic                done_tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = $clog2(MAX_BITS / 8);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0] MAX_BITS_W = 17'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Bit i of the result is set when i lies below the effective digest length.
    function automatic logic [MAX_BITS-1:0] valid_mask(input logic [16:0] nbits);
        logic [MAX_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (17'(i) < nbits) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [MAX_BITS-1:0] buf_q, buf_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [16:0]         deff_s;
    logic [16:0]         nbytes_s;
    logic                baud_end_s;

    // Clamp the requested length and derive the byte count (17 bits so d+7 cannot wrap).
    always_comb begin
        if ({1'b0, d} > MAX_BITS_W) begin
            deff_s = MAX_BITS_W;
        end else begin
            deff_s = {1'b0, d};
        end
        nbytes_s   = (deff_s + 17'd7) >> 3;
        baud_end_s = (baud_q == BAUD_LAST);
    end

    // Next-state logic; the baud counter restarts on every state entry and every bit.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (transmit) begin
                    buf_d     = data & valid_mask(deff_s);
                    bit_idx_d = 3'd0;
                    if (nbytes_s == 17'd0) begin
                        state_d = S_DONE;
                    end else begin
                        byte_idx_d = BYTE_W'(nbytes_s - 17'd1);
                        state_d    = S_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (byte_idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q - BYTE_W'(1);
                        state_d    = S_START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DONE: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_START: begin
                txd_d  = 1'b0;
                busy_d = 1'b1;
            end
            S_DATA: begin
                txd_d  = buf_d[{byte_idx_d, bit_idx_d}];
                busy_d = 1'b1;
            end
            S_STOP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset to an idle line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TxD     = txd_q;
    assign busy    = busy_q;
    assign done_tx = done_q;

endmodule
